// File: rtl/lsu_sequencer.sv
// Load/store sequencer feeding the pseudo-MMU strobes.
// Sub-word stores read the word first so the MMU can merge the new bytes.
module lsu_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  fault_o,
    output logic [1:0]            fault_code_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [2:0]            mem_funct3_o,
    output logic [DATA_WIDTH-1:0] mem_wd_o,
    output logic                  mem_rd_n_o,
    output logic                  mem_wr_n_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_i,
    input  logic                  mem_rdy_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE, ERR} state_t;

    state_t        state;
    logic          store;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          legal;
    logic          misal;

    assign cnt_nx = cnt + CW'(1);

    always_comb begin
        legal = 1'b0;
        if (we_i)
            legal = funct3_i inside {3'b000, 3'b001, 3'b010};
        else
            legal = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misal = ((funct3_i[1:0] == 2'b01) && addr_i[0])
             || ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            store        <= 1'b0;
            cnt          <= '0;
            rdata_o      <= '0;
            fault_code_o <= 2'b00;
            mem_addr_o   <= '0;
            mem_funct3_o <= 3'b000;
            mem_wd_o     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_i) begin
                        mem_addr_o   <= addr_i;
                        mem_funct3_o <= funct3_i;
                        mem_wd_o     <= wdata_i;
                        store        <= we_i;
                        cnt          <= '0;
                        fault_code_o <= 2'b00;
                        // funct3 legality outranks alignment
                        if (!legal) begin
                            state        <= ERR;
                            fault_code_o <= 2'b10;
                        end else if (misal) begin
                            state        <= ERR;
                            fault_code_o <= 2'b01;
                        end else if (we_i && funct3_i[1:0] == 2'b10) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (mem_rdy_i) begin
                        state <= CAP;
                    end else if (cnt_nx == TLIM) begin
                        state        <= ERR;
                        fault_code_o <= 2'b11;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                CAP: begin
                    if (store) begin
                        state <= WR;
                        cnt   <= '0;
                    end else begin
                        rdata_o <= mem_rd_i;
                        state   <= DONE;
                    end
                end
                WR: begin
                    if (mem_rdy_i) begin
                        state <= DONE;
                    end else if (cnt_nx == TLIM) begin
                        state        <= ERR;
                        fault_code_o <= 2'b11;
                    end else begin
                        cnt <= cnt_nx;
                    end
                end
                DONE: state <= IDLE;
                ERR:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes and pulses come straight off the state register
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE);
    assign fault_o    = (state == ERR);
    assign mem_rd_n_o = !((state == RD) || (state == CAP));
    assign mem_wr_n_o = (state != WR);

endmodule

// File: tb/tb_lsu_sequencer.sv
// Scoreboard bench for lsu_sequencer: cycle-level strobe checks
// plus a queue of expected completions popped on done/fault pulses.
module tb_lsu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, fault;
    logic [31:0] rdata;
    logic [1:0]  code;
    logic [31:0] m_addr, m_wd;
    logic [2:0]  m_f3;
    logic        rd_n, wr_n;
    logic [31:0] m_rd = '0;
    logic        m_rdy = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        flt;
        logic [31:0] rd;
        logic [1:0]  code;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_rdata = '0;

    lsu_sequencer #(.DATA_WIDTH(32), .TIMEOUT(15)) dut (
        .clk_i(clk), .reset_i(rst), .req_i(req), .we_i(we),
        .funct3_i(f3), .addr_i(addr), .wdata_i(wdata),
        .busy_o(busy), .done_o(done), .rdata_o(rdata),
        .fault_o(fault), .fault_code_o(code),
        .mem_addr_o(m_addr), .mem_funct3_o(m_f3), .mem_wd_o(m_wd),
        .mem_rd_n_o(rd_n), .mem_wr_n_o(wr_n),
        .mem_rd_i(m_rd), .mem_rdy_i(m_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {rd_n, wr_n, busy, done, fault} sampled mid-cycle
    task automatic cyc(input string tag, input logic [4:0] e);
        @(negedge clk);
        chk(tag, {27'd0, rd_n, wr_n, busy, done, fault}, {27'd0, e});
    endtask

    task automatic issue(input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic flt, input logic [1:0] c);
        exp_t e;
        @(negedge clk);
        req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
        if (!flt && !w) exp_rdata = m_rd;
        e.flt = flt; e.rd = exp_rdata; e.code = c;
        sb.push_back(e);
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done || fault) begin
            if (sb.size() == 0) begin
                chk("spurious", {30'd0, done, fault}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("kind", {31'd0, fault}, {31'd0, e.flt});
                chk("rdata", rdata, e.rd);
                if (e.flt) chk("code", {30'd0, code}, {30'd0, e.code});
            end
        end
    end

    localparam logic [4:0] S_IDLE = 5'b11000;
    localparam logic [4:0] S_RD   = 5'b01100;
    localparam logic [4:0] S_WR   = 5'b10100;
    localparam logic [4:0] S_DONE = 5'b11110;
    localparam logic [4:0] S_ERR  = 5'b11101;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ctl", {27'd0, rd_n, wr_n, busy, done, fault}, {27'd0, S_IDLE});
        chk("rst_data", rdata | m_addr | m_wd, 32'd0);
        chk("rst_f3code", {27'd0, m_f3, code}, 32'd0);
        rst = 1'b0;

        // word load
        m_rd = 32'hDEAD_BEEF;
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 2'b00);
        cyc("ld_c1", S_RD);
        chk("ld_addr", m_addr, 32'h10);
        cyc("ld_c2", S_RD);
        cyc("ld_c3", S_DONE);
        cyc("ld_c4", S_IDLE);

        // byte store with read-modify-write
        m_rd = 32'h1234_5678;
        issue(1'b1, 3'b000, 32'h13, 32'hA5, 1'b0, 2'b00);
        cyc("sb_c1", S_RD);
        chk("sb_a1", m_addr, 32'h13);
        cyc("sb_c2", S_RD);
        chk("sb_a2", m_addr, 32'h13);
        cyc("sb_c3", S_WR);
        chk("sb_a3", m_addr, 32'h13);
        chk("sb_wd", m_wd, 32'hA5);
        cyc("sb_c4", S_DONE);

        // word store
        issue(1'b1, 3'b010, 32'h4, 32'hCAFE_0001, 1'b0, 2'b00);
        cyc("sw_c1", S_WR);
        cyc("sw_c2", S_DONE);
        cyc("sw_c3", S_IDLE);

        // unsigned byte load at odd address
        m_rd = 32'h0000_00C3;
        issue(1'b0, 3'b100, 32'h3, 32'h0, 1'b0, 2'b00);
        repeat (2) cyc("lbu_rd", S_RD);
        cyc("lbu_done", S_DONE);

        // faults
        issue(1'b0, 3'b001, 32'h1, 32'h0, 1'b1, 2'b01);
        cyc("mis_c1", S_ERR);
        cyc("mis_c2", S_IDLE);
        chk("mis_hold", {30'd0, code}, 32'd1);
        issue(1'b1, 3'b100, 32'h8, 32'h0, 1'b1, 2'b10);
        cyc("ill_c1", S_ERR);
        issue(1'b0, 3'b011, 32'h1, 32'h0, 1'b1, 2'b10);
        cyc("prio_c1", S_ERR);
        issue(1'b0, 3'b010, 32'h2, 32'h0, 1'b1, 2'b01);
        cyc("misw_c1", S_ERR);
        issue(1'b1, 3'b001, 32'h6, 32'h0, 1'b0, 2'b00);
        repeat (2) cyc("sh_rd", S_RD);
        cyc("sh_wr", S_WR);
        cyc("sh_done", S_DONE);

        // read timeout
        m_rdy = 1'b0;
        issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 2'b11);
        for (int i = 0; i < 15; i++) cyc("to_rd", S_RD);
        cyc("to_err", S_ERR);
        cyc("to_idle", S_IDLE);

        // write timeout
        issue(1'b1, 3'b010, 32'h24, 32'h0, 1'b1, 2'b11);
        for (int i = 0; i < 15; i++) cyc("tow_wr", S_WR);
        cyc("tow_err", S_ERR);

        // reset in the middle of a write
        @(negedge clk);
        req = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h28;
        @(posedge clk);
        #1 req = 1'b0;
        cyc("rw_c1", S_WR);
        #2 rst = 1'b1;
        #1 chk("rw_async", {27'd0, rd_n, wr_n, busy, done, fault}, {27'd0, S_IDLE});
        exp_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        m_rdy = 1'b1;
        cyc("rw_after", S_IDLE);

        // request held high while busy yields one completion
        m_rd = 32'h0BAD_F00D;
        issue(1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 2'b00);
        req = 1'b1; addr = 32'h40;
        cyc("bz_c1", S_RD);
        cyc("bz_c2", S_RD);
        cyc("bz_c3", S_DONE);
        @(negedge clk);
        req = 1'b0;
        chk("bz_c4", {27'd0, rd_n, wr_n, busy, done, fault}, {27'd0, S_IDLE});
        cyc("bz_c5", S_IDLE);
        chk("bz_addr", m_addr, 32'h30);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_sequencer.md
Name: lsu_sequencer

Overview:
Load/store sequencer directly upstream of the pseudo-MMU. It accepts one memory request at a time from the control matrix, checks alignment and funct3 legality, and drives the MMU's active-low read/write strobes, address, funct3 and write data. It performs read-modify-write for byte and halfword stores, because the MMU merges store data into the word it has just read. It returns load data, a done pulse and fault status.

Parameters:
DATA_WIDTH, 32, data/address width
TIMEOUT, 15, max cycles to wait for mem_rdy_i in a strobe state before faulting (counter width = $clog2(TIMEOUT+1))

Ports:
clk_i  input  1  clock, pos-edge
reset_i  input  1  asynchronous reset, active-high
req_i  input  1  request strobe; sampled only in IDLE
we_i  input  1  1 = store, 0 = load
funct3_i  input  3  instruction funct3 (size/sign)
addr_i  input  DATA_WIDTH  byte address
wdata_i  input  DATA_WIDTH  store data (low bytes used for sub-word)
busy_o  output  1  high whenever state != IDLE
done_o  output  1  one-cycle pulse on successful completion
rdata_o  output  DATA_WIDTH  load result (already sized/extended by the MMU)
fault_o  output  1  one-cycle pulse on abort
fault_code_o  output  2  01 misaligned, 10 illegal funct3, 11 timeout; held until next accept
mem_addr_o  output  DATA_WIDTH  byte address to MMU (latched)
mem_funct3_o  output  3  funct3 to MMU (latched)
mem_wd_o  output  DATA_WIDTH  write data to MMU (latched)
mem_rd_n_o  output  1  MMU read strobe, active-low
mem_wr_n_o  output  1  MMU write strobe, active-low
mem_rd_i  input  DATA_WIDTH  MMU read data
mem_rdy_i  input  1  MMU ready, active-high

Behaviour:
- Reset (async): state IDLE; mem_rd_n_o = mem_wr_n_o = 1; busy_o, done_o and fault_o = 0; rdata_o, mem_addr_o, mem_wd_o = 0; mem_funct3_o = 0; fault_code_o = 00; timeout counter = 0. Reset mid-operation deasserts both strobes immediately and aborts with no done or fault pulse.
- States: IDLE, RD, CAP, WR, DONE, ERR. Strobes and pulses are decoded from the state register only.
- IDLE with req_i=1: latch addr, funct3 and wdata into mem_* outputs; clear fault_code_o; then check legality.
  - Loads: funct3 in {000,001,010,100,101} is legal.
  - Stores: funct3 in {000,001,010} is legal.
  - Illegal funct3 -> ERR with code 10.
  - Misaligned (halfword with addr[0]=1, or word with addr[1:0]!=00) -> ERR with code 01.
  - Illegal funct3 takes priority over misalignment.
  - Legal load -> RD.
  - Legal word store -> WR.
  - Legal byte or halfword store -> RD.
- RD: mem_rd_n_o=0. Advance to CAP when mem_rdy_i=1; otherwise stay and increment the counter.
- CAP: mem_rd_n_o stays 0 so the MMU output stays formatted. At the edge, rdata_o <= mem_rd_i for loads only. Load -> DONE; store -> WR.
- WR: mem_wr_n_o=0 with mem_rd_n_o=1. The write commits on the edge where mem_rdy_i=1, then -> DONE. Otherwise stay and increment the counter.
- Timeout: the counter clears on entry to RD and WR. If it reaches TIMEOUT while mem_rdy_i=0 -> ERR with code 11; no write is committed.
- DONE: done_o=1 for one cycle -> IDLE.
- ERR: fault_o=1 for one cycle -> IDLE. Neither strobe is ever asserted on the misaligned or illegal path.
- req_i is ignored while busy_o=1. A req_i in the cycle DONE or ERR returns to IDLE is not accepted until the following IDLE cycle.
- Both strobes are never low in the same cycle.
- Latency with mem_rdy_i=1 (accept edge = edge 0):
  - Load: done_o high in cycle 3.
  - Word store: done_o high in cycle 2.
  - Sub-word store: done_o high in cycle 4.
  - Fault: fault_o high in cycle 1.
- rdata_o holds its value across stores and faults.

Test Plan:
- Word load, addr 0x0000_0010, funct3 010, mem_rd_i=0xDEAD_BEEF -> mem_rd_n_o low in cycles 1-2; done_o in cycle 3; rdata_o=0xDEAD_BEEF; mem_wr_n_o stays 1.
- Byte store, addr 0x0000_0013, funct3 000, wdata 0x0000_00A5 -> sequence RD, CAP, WR; mem_wr_n_o low only in cycle 3; mem_addr_o=0x13 throughout; done_o in cycle 4; rdata_o unchanged.
- Word store, addr 0x0000_0004 -> no read strobe; mem_wr_n_o low in cycle 1; done_o in cycle 2.
- Halfword load at addr 0x0000_0001 -> fault_o in cycle 1; fault_code_o=01; no strobe asserted. Store with funct3 100 -> fault_code_o=10.
- Load with mem_rdy_i held 0 and TIMEOUT=15 -> mem_rd_n_o low for 15 cycles, then fault_o, fault_code_o=11, both strobes high, busy_o=0 the next cycle.
- reset_i pulsed mid-WR -> mem_wr_n_o returns to 1 asynchronously, busy_o=0, no done or fault pulse. A second req_i asserted during busy is ignored: exactly one done_o is produced.
